// File: rtl/cnn_window_gen_pkg.sv
// Shared geometry for the sliding-window generator and the kernel/accumulator stage.
// Window packing: element (ky,kx) at bits [(ky*KX+kx)*I_F_BW +: I_F_BW].
package cnn_window_gen_pkg;

   localparam int I_F_BW = 8;
   localparam int KX     = 5;
   localparam int KY     = 5;
   localparam int IW     = 28;
   localparam int IH     = 28;

   localparam int WIN_BW        = KX * KY * I_F_BW;
   localparam int OUT_W         = IW - KX + 1;
   localparam int OUT_H         = IH - KY + 1;
   localparam int WIN_PER_FRAME = OUT_W * OUT_H;

   localparam logic PH_FILL   = 1'b0;
   localparam logic PH_STREAM = 1'b1;

endpackage

// File: rtl/cnn_line_buffer.sv
// Single-row delay line: o_data is the sample accepted DEPTH enables ago.
// Contents are never cleared; the window generator gates out stale rows.
module cnn_line_buffer
   import cnn_window_gen_pkg::*;
#(
   parameter int DW    = I_F_BW,
   parameter int DEPTH = IW
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (i_en) begin
         mem_d[0] = i_data;
         for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign o_data = mem_q[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// Streaming KXxKY stride-1 window generator over a raster-order pixel stream.
//   phase     | meaning
//   PH_FILL   | row < KY-1, line buffers still filling, no windows
//   PH_STREAM | row >= KY-1, a window per pixel once col >= KX-1
module cnn_window_gen
   import cnn_window_gen_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_in_valid,
   input  logic [I_F_BW-1:0] i_pixel,
   output logic              o_ot_valid,
   output logic [WIN_BW-1:0] o_window,
   output logic              o_frame_done
);

   localparam int COL_W = $clog2(IW);
   localparam int ROW_W = $clog2(IH);

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              o_ot_valid_q, o_ot_valid_d;
   logic              o_frame_done_q, o_frame_done_d;
   logic [WIN_BW-1:0] o_window_q, o_window_d;

   logic [I_F_BW-1:0] tap     [KY-1];
   logic [I_F_BW-1:0] col_new [KY];
   logic [I_F_BW-1:0] sr_q    [KY][KX];
   logic [I_F_BW-1:0] sr_d    [KY][KX];
   logic [WIN_BW-1:0] win_flat;
   logic              phase;
   logic              col_last, row_last, win_hit;

   // tap[k] is the pixel k+1 rows above the incoming one
   for (genvar k = 0; k < KY-1; k++) begin : g_lb
      if (k == 0) begin : g_first
         cnn_line_buffer #(.DW(I_F_BW), .DEPTH(IW)) u_lb (
            .clk    (clk),
            .i_en   (i_in_valid),
            .i_data (i_pixel),
            .o_data (tap[k])
         );
      end else begin : g_chain
         cnn_line_buffer #(.DW(I_F_BW), .DEPTH(IW)) u_lb (
            .clk    (clk),
            .i_en   (i_in_valid),
            .i_data (tap[k-1]),
            .o_data (tap[k])
         );
      end
   end

   always_comb begin
      col_new[KY-1] = i_pixel;
      for (int ky = 0; ky < KY-1; ky++) begin
         col_new[ky] = tap[KY-2-ky];
      end
   end

   // Newest column enters at kx=KX-1; sr_d already includes it for packing
   always_comb begin
      sr_d = sr_q;
      if (i_in_valid) begin
         for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX-1; kx++) begin
               sr_d[ky][kx] = sr_q[ky][kx+1];
            end
            sr_d[ky][KX-1] = col_new[ky];
         end
      end
   end

   always_comb begin
      win_flat = '0;
      for (int ky = 0; ky < KY; ky++) begin
         for (int kx = 0; kx < KX; kx++) begin
            win_flat[(ky*KX+kx)*I_F_BW +: I_F_BW] = sr_d[ky][kx];
         end
      end
   end

   always_comb begin
      phase    = (row_q >= ROW_W'(KY-1)) ? PH_STREAM : PH_FILL;
      col_last = (col_q == COL_W'(IW-1));
      row_last = (row_q == ROW_W'(IH-1));
      win_hit  = i_in_valid && (phase == PH_STREAM) && (col_q >= COL_W'(KX-1));

      col_d = col_q;
      row_d = row_q;
      if (i_in_valid) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end

      o_ot_valid_d   = win_hit;
      o_frame_done_d = win_hit && col_last && row_last;
      o_window_d     = win_hit ? win_flat : o_window_q;
   end

   always_ff @(posedge clk) begin
      sr_q <= sr_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q          <= '0;
         row_q          <= '0;
         o_ot_valid_q   <= 1'b0;
         o_frame_done_q <= 1'b0;
         o_window_q     <= '0;
      end else begin
         col_q          <= col_d;
         row_q          <= row_d;
         o_ot_valid_q   <= o_ot_valid_d;
         o_frame_done_q <= o_frame_done_d;
         o_window_q     <= o_window_d;
      end
   end

   assign o_ot_valid   = o_ot_valid_q;
   assign o_frame_done = o_frame_done_q;
   assign o_window     = o_window_q;

endmodule
